// File: rtl/psx_dmac_pkg.sv
// Shared definitions for the DMAC Wishbone master.
//   - dmac_state_e : channel sequencer states
//   - DIR_*        : CHCR direction encodings
//   - ADDR_STEP    : byte stride between consecutive words
//   - WORDS_MAX    : word count implied by a BCR value of 0
package psx_dmac_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_CHOP,
    ST_DRAIN,
    ST_DONE,
    ST_ERROR
  } dmac_state_e;

  localparam logic        DIR_MEM_TO_DEV = 1'b0;
  localparam logic        DIR_DEV_TO_MEM = 1'b1;
  localparam logic [31:0] ADDR_STEP      = 32'd4;
  localparam logic [16:0] WORDS_MAX      = 17'h1_0000;

  // BCR value 0 encodes the full 64K-word transfer.
  function automatic logic [16:0] words_decode(input logic [15:0] w);
    return (w == 16'd0) ? WORDS_MAX : {1'b0, w};
  endfunction

endpackage

// File: rtl/dmac_rd_fifo.sv
// Read-return buffer: synchronous FIFO with combinational head output.
//   clk_i, rst_sync_n_i : clock, synchronous active-low reset
//   flush_i             : empties the FIFO at the next edge
//   push_i/push_data_i  : write port (ignored when full)
//   pop_i               : consume head (ignored when empty)
//   pop_data_o          : current head word, no output register
//   count_o, empty_o    : occupancy
module dmac_rd_fifo #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_sync_n_i,
  input  logic                        flush_i,
  input  logic                        push_i,
  input  logic [31:0]                 push_data_i,
  input  logic                        pop_i,
  output logic [31:0]                 pop_data_o,
  output logic [$clog2(FIFO_DEPTH):0] count_o,
  output logic                        empty_o
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  logic [31:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push, do_pop;

  assign do_push = push_i && (count_q != (AW+1)'(FIFO_DEPTH));
  assign do_pop  = pop_i && (count_q != '0);

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  // Depth is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk_i) begin
    if (!rst_sync_n_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  assign pop_data_o = mem_q[rd_ptr_q];
  assign count_o    = count_q;
  assign empty_o    = (count_q == '0);

endmodule

// File: rtl/dmac_wb_master.sv
// Wishbone B4 pipelined initiator for one DMA channel block transfer.
// Reads stream memory words to the device port; writes stream device
// words to memory. Produces DONE (TR self-clear) and ERR pulses.
//   CLK, RST_SYNC_N          : clock, synchronous active-low reset
//   START_IN, CFG_*          : transfer request and MADR/BCR/CHCR config
//   BUSY/DONE/ERR_OUT        : status; MADR_NEXT_OUT next unissued address
//   WB_*                     : memory-side Wishbone pipelined master
//   DEV_WR_* / DEV_RD_*      : device stream (to device / from device)
// Optional: define DMAC_WB_BURST_CHOP_EN to split the transfer into
// CYC tenures of BURST_LEN words separated by one idle CYC cycle.
module dmac_wb_master
  import psx_dmac_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned BURST_LEN  = 16
) (
  input  logic        CLK,
  input  logic        RST_SYNC_N,
  input  logic        START_IN,
  input  logic [31:0] CFG_MADR_IN,
  input  logic [15:0] CFG_WORDS_IN,
  input  logic        CFG_DIR_IN,
  input  logic        CFG_STEP_DEC_IN,
  output logic        BUSY_OUT,
  output logic        DONE_OUT,
  output logic        ERR_OUT,
  output logic [31:0] MADR_NEXT_OUT,
  output logic        WB_CYC_OUT,
  output logic        WB_STB_OUT,
  output logic        WB_WE_OUT,
  output logic [31:0] WB_ADR_OUT,
  output logic [3:0]  WB_SEL_OUT,
  output logic [31:0] WB_DAT_WR_OUT,
  input  logic [31:0] WB_DAT_RD_IN,
  input  logic        WB_ACK_IN,
  input  logic        WB_STALL_IN,
  input  logic        WB_ERR_IN,
  output logic [31:0] DEV_WR_DATA_OUT,
  output logic        DEV_WR_VALID_OUT,
  input  logic        DEV_WR_READY_IN,
  input  logic [31:0] DEV_RD_DATA_IN,
  input  logic        DEV_RD_VALID_IN,
  output logic        DEV_RD_READY_OUT
);
  localparam int unsigned OW = $clog2(FIFO_DEPTH) + 1;

  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0
      || BURST_LEN < 1) begin : g_bad_cfg
    $error("dmac_wb_master: illegal FIFO_DEPTH/BURST_LEN");
  end

  dmac_state_e state_q;
  logic        cyc_q, dir_q, dec_q;
  logic [31:0] addr_q;
  logic [16:0] words_q, issued_q, acked_q;
  logic [OW-1:0] outst_q;
`ifdef DMAC_WB_BURST_CHOP_EN
  logic [16:0] tcnt_q;
`endif

  logic [OW-1:0] fifo_cnt;
  logic          fifo_empty, stb, issue, ack_take, err_take, last_issue;
  logic          rd_credit, wr_credit, unused_addr_lsb;

  // Bus responses only count while a tenure is open; late ones drop out.
  assign err_take = cyc_q && WB_ERR_IN;
  assign ack_take = cyc_q && WB_ACK_IN && !WB_ERR_IN;

  // Reads reserve FIFO room for everything in flight, so pushes never overflow.
  assign rd_credit = ({1'b0, outst_q} + {1'b0, fifo_cnt}) < (OW+1)'(FIFO_DEPTH);
  assign wr_credit = outst_q < OW'(FIFO_DEPTH);

  assign stb = (state_q == ST_ACTIVE) && (issued_q < words_q) &&
               ((dir_q == DIR_DEV_TO_MEM) ? (DEV_RD_VALID_IN && wr_credit) : rd_credit);
  assign issue      = stb && !WB_STALL_IN;
  assign last_issue = issue && ((issued_q + 17'd1) == words_q);

  assign unused_addr_lsb = ^CFG_MADR_IN[1:0];

  dmac_rd_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_rd_fifo (
    .clk_i        (CLK),
    .rst_sync_n_i (RST_SYNC_N),
    .flush_i      (err_take),
    .push_i       (ack_take && (dir_q == DIR_MEM_TO_DEV)),
    .push_data_i  (WB_DAT_RD_IN),
    .pop_i        (DEV_WR_READY_IN),
    .pop_data_o   (DEV_WR_DATA_OUT),
    .count_o      (fifo_cnt),
    .empty_o      (fifo_empty)
  );

  always_ff @(posedge CLK) begin
    if (!RST_SYNC_N) begin
      state_q  <= ST_IDLE;
      cyc_q    <= 1'b0;
      dir_q    <= DIR_MEM_TO_DEV;
      dec_q    <= 1'b0;
      addr_q   <= '0;
      words_q  <= '0;
      issued_q <= '0;
      acked_q  <= '0;
      outst_q  <= '0;
`ifdef DMAC_WB_BURST_CHOP_EN
      tcnt_q   <= '0;
`endif
    end else begin
      if (issue) begin
        addr_q   <= dec_q ? (addr_q - ADDR_STEP) : (addr_q + ADDR_STEP);
        issued_q <= issued_q + 17'd1;
      end
      if (ack_take) acked_q <= acked_q + 17'd1;
      if (issue && !ack_take)      outst_q <= outst_q + OW'(1);
      else if (!issue && ack_take) outst_q <= outst_q - OW'(1);
`ifdef DMAC_WB_BURST_CHOP_EN
      if (issue) tcnt_q <= tcnt_q + 17'd1;
`endif

      case (state_q)
        ST_IDLE: if (START_IN) begin
          dir_q    <= CFG_DIR_IN;
          dec_q    <= CFG_STEP_DEC_IN;
          addr_q   <= {CFG_MADR_IN[31:2], 2'b00};
          words_q  <= words_decode(CFG_WORDS_IN);
          issued_q <= '0;
          acked_q  <= '0;
          outst_q  <= '0;
`ifdef DMAC_WB_BURST_CHOP_EN
          tcnt_q   <= '0;
`endif
          cyc_q    <= 1'b1;
          state_q  <= ST_ACTIVE;
        end
        ST_ACTIVE: begin
          if (last_issue) state_q <= ST_DRAIN;
`ifdef DMAC_WB_BURST_CHOP_EN
          else if (issue && tcnt_q == 17'(BURST_LEN - 1)) state_q <= ST_CHOP;
`endif
        end
`ifdef DMAC_WB_BURST_CHOP_EN
        // Close the tenure once quiet, keep CYC low one cycle, reopen.
        ST_CHOP: begin
          if (cyc_q) begin
            if (outst_q == '0) cyc_q <= 1'b0;
          end else begin
            cyc_q   <= 1'b1;
            tcnt_q  <= '0;
            state_q <= ST_ACTIVE;
          end
        end
`endif
        ST_DRAIN: if (acked_q == words_q && (dir_q == DIR_DEV_TO_MEM || fifo_empty)) begin
          cyc_q   <= 1'b0;
          state_q <= ST_DONE;
        end
        ST_DONE:  state_q <= ST_IDLE;
        ST_ERROR: state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase

      // Error beats any simultaneous ACK or state transition.
      if (err_take) begin
        cyc_q   <= 1'b0;
        state_q <= ST_ERROR;
      end
    end
  end

  assign BUSY_OUT         = (state_q != ST_IDLE);
  assign DONE_OUT         = (state_q == ST_DONE);
  assign ERR_OUT          = (state_q == ST_ERROR);
  assign MADR_NEXT_OUT    = addr_q;
  assign WB_CYC_OUT       = cyc_q;
  assign WB_STB_OUT       = stb;
  assign WB_WE_OUT        = cyc_q && (dir_q == DIR_DEV_TO_MEM);
  assign WB_ADR_OUT       = addr_q;
  assign WB_SEL_OUT       = 4'hF;
  assign WB_DAT_WR_OUT    = (stb && dir_q == DIR_DEV_TO_MEM) ? DEV_RD_DATA_IN : 32'd0;
  assign DEV_WR_VALID_OUT = !fifo_empty;
  assign DEV_RD_READY_OUT = issue && (dir_q == DIR_DEV_TO_MEM);

endmodule

// File: tb/tb_dmac_wb_master.sv
// Bench for dmac_wb_master: vector table + random transfers against a
// transfer-level model (address sequence, memory contents, device data).
module tb_dmac_wb_master;
  localparam int DEPTH    = 4;
  localparam int TB_BURST = 2;

  logic        CLK = 1'b0;
  logic        RST_SYNC_N, START_IN, CFG_DIR_IN, CFG_STEP_DEC_IN;
  logic [31:0] CFG_MADR_IN;
  logic [15:0] CFG_WORDS_IN;
  logic        BUSY_OUT, DONE_OUT, ERR_OUT;
  logic [31:0] MADR_NEXT_OUT;
  logic        WB_CYC_OUT, WB_STB_OUT, WB_WE_OUT;
  logic [31:0] WB_ADR_OUT, WB_DAT_WR_OUT, WB_DAT_RD_IN;
  logic [3:0]  WB_SEL_OUT;
  logic        WB_ACK_IN, WB_STALL_IN, WB_ERR_IN;
  logic [31:0] DEV_WR_DATA_OUT, DEV_RD_DATA_IN;
  logic        DEV_WR_VALID_OUT, DEV_WR_READY_IN, DEV_RD_VALID_IN, DEV_RD_READY_OUT;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  dmac_wb_master #(.FIFO_DEPTH(DEPTH), .BURST_LEN(TB_BURST)) dut (
    .CLK(CLK), .RST_SYNC_N(RST_SYNC_N), .START_IN(START_IN),
    .CFG_MADR_IN(CFG_MADR_IN), .CFG_WORDS_IN(CFG_WORDS_IN), .CFG_DIR_IN(CFG_DIR_IN),
    .CFG_STEP_DEC_IN(CFG_STEP_DEC_IN), .BUSY_OUT(BUSY_OUT), .DONE_OUT(DONE_OUT),
    .ERR_OUT(ERR_OUT), .MADR_NEXT_OUT(MADR_NEXT_OUT), .WB_CYC_OUT(WB_CYC_OUT),
    .WB_STB_OUT(WB_STB_OUT), .WB_WE_OUT(WB_WE_OUT), .WB_ADR_OUT(WB_ADR_OUT),
    .WB_SEL_OUT(WB_SEL_OUT), .WB_DAT_WR_OUT(WB_DAT_WR_OUT), .WB_DAT_RD_IN(WB_DAT_RD_IN),
    .WB_ACK_IN(WB_ACK_IN), .WB_STALL_IN(WB_STALL_IN), .WB_ERR_IN(WB_ERR_IN),
    .DEV_WR_DATA_OUT(DEV_WR_DATA_OUT), .DEV_WR_VALID_OUT(DEV_WR_VALID_OUT),
    .DEV_WR_READY_IN(DEV_WR_READY_IN), .DEV_RD_DATA_IN(DEV_RD_DATA_IN),
    .DEV_RD_VALID_IN(DEV_RD_VALID_IN), .DEV_RD_READY_OUT(DEV_RD_READY_OUT)
  );

  typedef struct {
    bit          dir;
    logic [31:0] madr;
    int          words;
    bit          dec;
    int          stall_pct, rdy_pct, ack_pct, err_at, rdy_hold, exp_hold_issues;
    logic [31:0] exp_next;
    int          exp_done, exp_err;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] devf(input int i);
    return 32'hD000_0000 + 32'(i) * 32'h0001_0003;
  endfunction

  function automatic logic [31:0] nth_addr(input logic [31:0] base, input bit dec, input int i);
    return dec ? base - 32'(4 * i) : base + 32'(4 * i);
  endfunction

  task automatic run_xfer(input vec_t v, input string tag);
    logic [31:0] base, prev_adr, prev_dat;
    logic [31:0] pend[$];
    int issued, popped, resp, ndone, nerr, nchop, lowcyc, fin_cnt, exp_chop;
    bit resp_now, err_seen, err_chk, late_ack, consumed, prev_ss, prev_cyc, ok_fifo, ok_stall;
    base = {v.madr[31:2], 2'b00};
    issued = 0; popped = 0; resp = 0; ndone = 0; nerr = 0; nchop = 0; lowcyc = 0; fin_cnt = 0;
    err_seen = 0; err_chk = 0; late_ack = 0; consumed = 0; prev_ss = 0; ok_fifo = 1; ok_stall = 1;
    prev_adr = '0; prev_dat = '0;
    DEV_RD_VALID_IN = 0;
    @(posedge CLK); #1;
    START_IN = 1; CFG_MADR_IN = v.madr; CFG_WORDS_IN = 16'(v.words);
    CFG_DIR_IN = v.dir; CFG_STEP_DEC_IN = v.dec;
    @(posedge CLK); #1;
    START_IN = 0;
    prev_cyc = 1;
    for (int cyc = 0; cyc < 3000 && fin_cnt < 3; cyc++) begin
      WB_ACK_IN = 0; WB_ERR_IN = 0; WB_DAT_RD_IN = '0; resp_now = 0;
      if (late_ack) begin
        WB_ACK_IN = 1; WB_DAT_RD_IN = 32'hBAD0_BAD0; late_ack = 0;
      end else if (!err_seen && pend.size() > 0 && $urandom_range(99) < v.ack_pct) begin
        resp_now = 1; resp++;
        if (resp == v.err_at) WB_ERR_IN = 1;
        else begin WB_ACK_IN = 1; WB_DAT_RD_IN = memf(pend[0]); end
      end
      WB_STALL_IN = ($urandom_range(99) < v.stall_pct);
      DEV_WR_READY_IN = (cyc >= v.rdy_hold) && ($urandom_range(99) < v.rdy_pct);
      if (consumed) begin DEV_RD_VALID_IN = 0; consumed = 0; end
      if (v.dir && !DEV_RD_VALID_IN && $urandom_range(3) != 0) begin
        DEV_RD_VALID_IN = 1; DEV_RD_DATA_IN = devf(issued);
      end
      #4;
      if (err_chk) begin
        chk({tag, "_err_cyc"}, WB_CYC_OUT, 0);
        chk({tag, "_err_pulse"}, ERR_OUT, 1);
        chk({tag, "_err_flush"}, DEV_WR_VALID_OUT, 0);
        err_chk = 0; late_ack = 1;
      end
      if (prev_ss && !err_seen &&
          !(WB_STB_OUT && WB_ADR_OUT == prev_adr && WB_DAT_WR_OUT == prev_dat)) ok_stall = 0;
      prev_ss = WB_STB_OUT && WB_STALL_IN; prev_adr = WB_ADR_OUT; prev_dat = WB_DAT_WR_OUT;
      if (resp_now) begin
        void'(pend.pop_front());
        if (WB_ERR_IN) begin err_seen = 1; err_chk = 1; end
      end
      if (WB_STB_OUT && !WB_STALL_IN) begin
        chk({tag, "_adr"}, WB_ADR_OUT, nth_addr(base, v.dec, issued));
        chk({tag, "_we"}, WB_WE_OUT, v.dir);
        if (v.dir) begin
          chk({tag, "_wdat"}, WB_DAT_WR_OUT, devf(issued));
          chk({tag, "_rd_ready"}, DEV_RD_READY_OUT, 1);
          consumed = 1;
        end
        pend.push_back(WB_ADR_OUT); issued++;
      end else if (DEV_RD_READY_OUT) chk({tag, "_rd_ready_spurious"}, DEV_RD_READY_OUT, 0);
      if (DEV_WR_VALID_OUT && DEV_WR_READY_IN) begin
        chk({tag, "_devdata"}, DEV_WR_DATA_OUT, memf(nth_addr(base, v.dec, popped)));
        popped++;
      end
      if (!v.dir && issued - popped > DEPTH) ok_fifo = 0;
      if (v.rdy_hold > 0 && cyc == v.rdy_hold - 1) begin
        chk({tag, "_hold_issues"}, issued, v.exp_hold_issues);
        chk({tag, "_hold_stb"}, WB_STB_OUT, 0);
      end
      if (DONE_OUT) begin
        ndone++;
        chk({tag, "_done_cyc"}, WB_CYC_OUT, 0);
        if (!v.dir) chk({tag, "_done_empty"}, popped, v.words);
      end
      if (ERR_OUT) nerr++;
      if (BUSY_OUT && !DONE_OUT && !ERR_OUT && !WB_CYC_OUT) lowcyc++;
      if (prev_cyc && !WB_CYC_OUT && BUSY_OUT && !DONE_OUT && !ERR_OUT) nchop++;
      prev_cyc = WB_CYC_OUT;
      if (fin_cnt > 0 || DONE_OUT || ERR_OUT) fin_cnt++;
      @(posedge CLK); #1;
    end
    #4;
    chk({tag, "_finished"}, fin_cnt != 0, 1);
    chk({tag, "_ndone"}, ndone, v.exp_done);
    chk({tag, "_nerr"}, nerr, v.exp_err);
    chk({tag, "_madr_model"}, MADR_NEXT_OUT, nth_addr(base, v.dec, issued));
    chk({tag, "_busy_end"}, BUSY_OUT, 0);
    chk({tag, "_cyc_end"}, WB_CYC_OUT, 0);
    chk({tag, "_fifo_credit"}, ok_fifo, 1);
    chk({tag, "_stall_hold"}, ok_stall, 1);
    if (v.exp_err == 0) begin
      chk({tag, "_madr_next"}, MADR_NEXT_OUT, v.exp_next);
      chk({tag, "_issued"}, issued, v.words);
      if (!v.dir) chk({tag, "_popped"}, popped, v.words);
`ifdef DMAC_WB_BURST_CHOP_EN
      exp_chop = (v.words - 1) / TB_BURST;
`else
      exp_chop = 0;
`endif
      chk({tag, "_chops"}, nchop, exp_chop);
      chk({tag, "_cyc_low_cycles"}, lowcyc, exp_chop);
    end
    DEV_RD_VALID_IN = 0; WB_ACK_IN = 0; WB_STALL_IN = 0;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_cyc"}, WB_CYC_OUT, 0);
    chk({tag, "_stb"}, WB_STB_OUT, 0);
    chk({tag, "_we"}, WB_WE_OUT, 0);
    chk({tag, "_busy"}, BUSY_OUT, 0);
    chk({tag, "_done"}, DONE_OUT, 0);
    chk({tag, "_err"}, ERR_OUT, 0);
    chk({tag, "_adr"}, WB_ADR_OUT, 0);
    chk({tag, "_madr"}, MADR_NEXT_OUT, 0);
    chk({tag, "_wvalid"}, DEV_WR_VALID_OUT, 0);
    chk({tag, "_rready"}, DEV_RD_READY_OUT, 0);
  endtask

  vec_t vecs[10];

  initial begin
    int iss, pend_n;
    vecs[0] = '{1'b0, 32'h0000_1000, 4, 1'b0,  0, 100, 100, 0,  0,     0, 32'h0000_1010, 1, 0};
    vecs[1] = '{1'b1, 32'h0000_0008, 3, 1'b1, 60, 100, 100, 0,  0,     0, 32'hFFFF_FFFC, 1, 0};
    vecs[2] = '{1'b0, 32'h0000_2000, 8, 1'b0,  0, 100, 100, 0, 20, DEPTH, 32'h0000_2020, 1, 0};
    vecs[3] = '{1'b0, 32'h0000_3000, 4, 1'b0,  0, 100, 100, 2,  0,     0, 32'h0000_0000, 0, 1};
    vecs[4] = '{1'b0, 32'hFFFF_FFF8, 4, 1'b0, 30,  60,  70, 0,  0,     0, 32'h0000_0008, 1, 0};
    vecs[5] = '{1'b1, 32'h0000_4001, 5, 1'b0, 20, 100,  60, 0,  0,     0, 32'h0000_4014, 1, 0};
    vecs[6] = '{1'b1, 32'h0000_0100, 4, 1'b1,  0, 100, 100, 3,  0,     0, 32'h0000_0000, 0, 1};
    vecs[7] = '{1'b0, 32'h0000_0123, 1, 1'b1,  0, 100, 100, 0,  0,     0, 32'h0000_011C, 1, 0};
    vecs[8] = '{1'b0, 32'h0000_5000, 5, 1'b0,  0, 100, 100, 0,  0,     0, 32'h0000_5014, 1, 0};
    vecs[9] = '{1'b1, 32'h0000_7000, 6, 1'b0, 30, 100,  50, 0,  0,     0, 32'h0000_7018, 1, 0};

    RST_SYNC_N = 0; START_IN = 0; CFG_MADR_IN = '0; CFG_WORDS_IN = '0; CFG_DIR_IN = 0;
    CFG_STEP_DEC_IN = 0; WB_DAT_RD_IN = '0; WB_ACK_IN = 0; WB_STALL_IN = 0; WB_ERR_IN = 0;
    DEV_WR_READY_IN = 0; DEV_RD_DATA_IN = '0; DEV_RD_VALID_IN = 0;
    repeat (3) @(posedge CLK);
    #1 RST_SYNC_N = 1;
    #4;
    chk_idle_outputs("reset");
    chk("reset_sel", WB_SEL_OUT, 32'hF);

    for (int i = 0; i < 10; i++) run_xfer(vecs[i], $sformatf("vec%0d", i));

    // Reset asserted in the cycle of the second issue of a 4-word read.
    @(posedge CLK); #1;
    START_IN = 1; CFG_MADR_IN = 32'h0000_6000; CFG_WORDS_IN = 16'd4; CFG_DIR_IN = 0;
    CFG_STEP_DEC_IN = 0; DEV_WR_READY_IN = 1;
    @(posedge CLK); #1;
    START_IN = 0; iss = 0; pend_n = 0;
    for (int c = 0; c < 20 && iss < 2; c++) begin
      WB_ACK_IN = (pend_n > 0); WB_DAT_RD_IN = 32'h1111_0000 + 32'(c);
      if (pend_n > 0) pend_n--;
      #4;
      if (WB_STB_OUT && !WB_STALL_IN) begin iss++; pend_n++; end
      if (iss == 2) RST_SYNC_N = 0;
      else begin @(posedge CLK); #1; end
    end
    chk("rst_reached_issue2", iss, 2);
    @(posedge CLK); #1;
    RST_SYNC_N = 1; WB_ACK_IN = 1; WB_DAT_RD_IN = 32'hDEAD_BEEF;
    #4;
    chk_idle_outputs("rst_mid");
    @(posedge CLK); #1;
    WB_ACK_IN = 0;
    #4;
    chk("rst_late_ack_valid", DEV_WR_VALID_OUT, 0);
    chk("rst_late_ack_busy", BUSY_OUT, 0);
    run_xfer('{1'b0, 32'h0000_6000, 4, 1'b0, 0, 100, 100, 0, 0, 0, 32'h0000_6010, 1, 0},
             "after_rst");

    for (int k = 0; k < 24; k++) begin
      vec_t r;
      r.dir = 1'($urandom_range(1)); r.madr = $urandom; r.words = $urandom_range(1, 12);
      r.dec = 1'($urandom_range(1)); r.stall_pct = $urandom_range(0, 50);
      r.rdy_pct = $urandom_range(30, 100); r.ack_pct = $urandom_range(40, 100);
      r.err_at = 0; r.rdy_hold = 0; r.exp_hold_issues = 0;
      r.exp_next = nth_addr({r.madr[31:2], 2'b00}, r.dec, r.words);
      r.exp_done = 1; r.exp_err = 0;
      run_xfer(r, $sformatf("rnd%0d", k));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
